// File: rtl/imem_loader.sv
// imem_loader -- boot loader for the instruction memory.
//   Takes a byte stream (word count, data words, XOR checksum), packs bytes
//   into 32-bit little-endian words and writes them to word-aligned addresses
//   from 0. The CPU is held in reset until an image passes the length and
//   checksum checks.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   start                pulse: (re)start a load from any state
//   rx_data/rx_valid     incoming byte stream; rx_ready accepts it
//   mem_we/addr/wdata    instruction-memory write port (1-cycle strobe)
//   busy/done/error      load status; cpu_rst_n high only once an image is accepted
module imem_loader #(
  parameter int LENGTH = 32,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_rst_n
);

  localparam int IW = $clog2(LENGTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       bcnt_q;
  logic [IW-1:0]    widx_q, len_q;
  logic [7:0]       csum_q;
  logic [31:0]      asm_q, asm_d;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [31:0]      wdata_q;

  // A byte arriving together with start belongs to no image and is dropped.
  logic acc, last_byte, last_word, n_ok;
  assign acc       = rx_valid && rx_ready && !start;
  assign last_byte = acc && (bcnt_q == 2'd3);
  assign last_word = (widx_q + IW'(1)) == len_q;

  // Word being assembled, including the byte accepted this cycle.
  always_comb begin
    asm_d = asm_q;
    if (acc) asm_d[{bcnt_q, 3'b000} +: 8] = rx_data;
  end

  assign n_ok = (asm_d != 32'd0) && (asm_d <= 32'(LENGTH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LEN;
    end else begin
      case (state_q)
        S_LEN:   if (last_byte) state_d = n_ok ? S_DATA : S_ERR;
        S_DATA:  if (last_byte && last_word) state_d = S_CSUM;
        S_CSUM:  if (acc) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs
  always_comb begin
    rx_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    busy      = rx_ready;
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
    cpu_rst_n = (state_q == S_DONE);
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Datapath: byte lane counter, word index, checksum, write port registers.
  // The write strobe is registered, so it lands the cycle after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      widx_q  <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      bcnt_q <= '0;
      widx_q <= '0;
      csum_q <= '0;
      asm_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (acc && (state_q == S_LEN || state_q == S_DATA)) begin
        bcnt_q <= bcnt_q + 2'd1;
        asm_q  <= asm_d;
      end
      if (state_q == S_LEN && last_byte) len_q <= IW'(asm_d);
      if (state_q == S_DATA && acc) begin
        csum_q <= csum_q ^ rx_data;
        if (last_byte) begin
          we_q    <= 1'b1;
          addr_q  <= WIDTH'({widx_q, 2'b00});
          wdata_q <= asm_d;
          widx_q  <= widx_q + IW'(1);
        end
      end
    end
  end

endmodule
